// File: rtl/fifo_arb_pkg.sv
// Shared types for the FIFO write-port arbiter: arbiter state and pointer-width helper.
// No timing content; pure declarations.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-bank and FIFO write-side signals shared by the arbiter (slave) and its driver (master).
// Zero-latency accept: a transfer happens on any rising edge with req[i] and gnt[i] both high.
interface fifo_wr_arbiter_if #(
  parameter int nreq  = 4,
  parameter int dwith = 8
);

  logic [nreq-1:0]       req;
  logic [nreq*dwith-1:0] req_data;
  logic [nreq-1:0]       gnt;
  logic                  fifo_we;
  logic [dwith-1:0]      fifo_din;
  logic                  fifo_full;
  logic                  rd_fire;

  modport master (
    output req, req_data, fifo_full, rd_fire,
    input  gnt, fifo_we, fifo_din
  );

  modport slave (
    input  req, req_data, fifo_full, rd_fire,
    output gnt, fifo_we, fifo_din
  );

endinterface

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set req bit scanning upward from start, wrapping modulo nreq.
// Purely combinational; no backpressure.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int nreq = 4
) (
  input  logic [nreq-1:0]          req,
  input  logic [ptr_w(nreq)-1:0]   start,
  output logic                     vld,
  output logic [ptr_w(nreq)-1:0]   idx
);

  localparam int PW = ptr_w(nreq);

  logic [2*nreq-1:0] dbl;
  logic [nreq-1:0]   rot;
  logic [PW-1:0]     off;
  logic [PW:0]       sum;

  // Rotate so bit 0 is req[start]; the lowest set bit of rot is the winner's offset.
  always_comb begin
    dbl = {req, req};
    rot = nreq'(dbl >> start);
    vld = 1'b0;
    off = '0;
    for (int i = nreq - 1; i >= 0; i--) begin
      if (rot[i]) begin
        vld = 1'b1;
        off = PW'(i);
      end
    end
    sum = {1'b0, start} + {1'b0, off};
    idx = (sum >= (PW+1)'(nreq)) ? PW'(sum - (PW+1)'(nreq)) : sum[PW-1:0];
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among nreq producers, with per-owner burst limit and level tracking.
// Zero-cycle accept (gnt is combinational); fifo_full forces gnt low and freezes arbitration state.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int nreq      = 4,
  parameter int dwith     = 8,
  parameter int dsize     = 8,
  parameter int max_burst = 2,
  parameter int af_thresh = 6
) (
  input  logic                      clk,
  input  logic                      nrst,
  fifo_wr_arbiter_if.slave          bus,
  output logic [$clog2(dsize):0]    level,
  output logic                      almost_full,
  output logic [ptr_w(nreq)-1:0]    owner
);

  localparam int PW = ptr_w(nreq);
  localparam int LW = $clog2(dsize) + 1;
  localparam int CW = $clog2(max_burst + 1);

  arb_state_e     state_q, state_d;
  logic [PW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]  owner_q, owner_d;
  logic [CW-1:0]  burst_cnt_q, burst_cnt_d;
  logic [LW-1:0]  level_q, level_d;
  logic           af_q, af_d;

  logic [nreq-1:0]  gnt_c;
  logic [nreq-1:0]  gnt;
  logic             take_new;
  logic [PW-1:0]    pick_start;
  logic [PW-1:0]    pick_idx;
  logic             pick_vld;
  logic             fifo_we;
  logic [dwith-1:0] fifo_din;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] x);
    return (x == PW'(nreq - 1)) ? '0 : x + 1'b1;
  endfunction

  // When a burst owner drops req, the search restarts just past it in the same cycle.
  assign pick_start = (state_q == BURST) ? wrap_inc(owner_q) : rr_ptr_q;

  rr_pick #(
    .nreq (nreq)
  ) u_pick (
    .req   (bus.req),
    .start (pick_start),
    .vld   (pick_vld),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    gnt_c       = '0;
    take_new    = 1'b0;

    if (!bus.fifo_full) begin
      if (state_q == BURST) begin
        if (bus.req[owner_q]) begin
          gnt_c[owner_q] = 1'b1;
          burst_cnt_d    = burst_cnt_q + 1'b1;
          if (burst_cnt_d == CW'(max_burst)) begin
            rr_ptr_d = wrap_inc(owner_q);
            state_d  = IDLE;
          end
        end else begin
          rr_ptr_d = wrap_inc(owner_q);
          state_d  = IDLE;
          take_new = 1'b1;
        end
      end else begin
        take_new = 1'b1;
      end

      if (take_new && pick_vld) begin
        gnt_c[pick_idx] = 1'b1;
        owner_d         = pick_idx;
        burst_cnt_d     = CW'(1);
        if (max_burst == 1) begin
          rr_ptr_d = wrap_inc(pick_idx);
          state_d  = IDLE;
        end else begin
          state_d  = BURST;
        end
      end
    end
  end

  // Grants must be silent while reset is held, even though the state already reads IDLE.
  assign gnt     = nrst ? gnt_c : '0;
  assign fifo_we = |(gnt & bus.req);

  always_comb begin
    fifo_din = '0;
    for (int i = 0; i < nreq; i++) begin
      if (gnt[i]) begin
        fifo_din = bus.req_data[i*dwith +: dwith];
      end
    end
  end

  always_comb begin
    level_d = level_q;
    if (fifo_we && !bus.rd_fire && (level_q != LW'(dsize))) begin
      level_d = level_q + 1'b1;
    end else if (bus.rd_fire && !fifo_we && (level_q != '0)) begin
      level_d = level_q - 1'b1;
    end
    af_d = (level_d >= LW'(af_thresh));
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
      level_q     <= '0;
      af_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      level_q     <= level_d;
      af_q        <= af_d;
    end
  end

  assign bus.gnt      = gnt;
  assign bus.fifo_we  = fifo_we;
  assign bus.fifo_din = fifo_din;
  assign level        = level_q;
  assign almost_full  = af_q;
  assign owner        = owner_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (nreq=4, max_burst=2, dsize=8, af_thresh=6).
// Requester i always presents data 8'hA0+i.
module tb_fifo_wr_arbiter;

  logic       clk;
  logic       nrst;
  logic [3:0] level;
  logic       almost_full;
  logic [1:0] owner;
  int         total;
  int         bad;

  fifo_wr_arbiter_if #(.nreq(4), .dwith(8)) bus ();

  fifo_wr_arbiter #(
    .nreq      (4),
    .dwith     (8),
    .dsize     (8),
    .max_burst (2),
    .af_thresh (6)
  ) dut (
    .clk         (clk),
    .nrst        (nrst),
    .bus         (bus),
    .level       (level),
    .almost_full (almost_full),
    .owner       (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // el is the level expected from the previous edge; eg is the grant expected this cycle.
  task automatic cyc(input string tag, input logic [3:0] r, input logic f, input logic rd,
                     input logic [3:0] eg, input int el);
    logic [7:0] ed;
    ed = 8'h00;
    @(negedge clk);
    chk({tag, ".lvl"}, 32'(level), 32'(el));
    chk({tag, ".af"}, 32'(almost_full), (el >= 6) ? 32'd1 : 32'd0);
    bus.req       = r;
    bus.fifo_full = f;
    bus.rd_fire   = rd;
    #1;
    for (int i = 0; i < 4; i++) if (eg[i]) ed = 8'hA0 + 8'(i);
    chk({tag, ".gnt"}, 32'(bus.gnt), 32'(eg));
    chk({tag, ".we"}, 32'(bus.fifo_we), 32'(|eg));
    chk({tag, ".din"}, 32'(bus.fifo_din), 32'(ed));
  endtask

  task automatic do_reset(input string tag, input logic [3:0] r);
    @(negedge clk);
    bus.req       = r;
    bus.fifo_full = 1'b0;
    bus.rd_fire   = 1'b0;
    nrst          = 1'b0;
    #1;
    chk({tag, ".gnt"}, 32'(bus.gnt), 32'd0);
    chk({tag, ".we"}, 32'(bus.fifo_we), 32'd0);
    chk({tag, ".lvl"}, 32'(level), 32'd0);
    chk({tag, ".af"}, 32'(almost_full), 32'd0);
    chk({tag, ".own"}, 32'(owner), 32'd0);
    @(negedge clk);
    bus.req = 4'b0000;
    nrst    = 1'b1;
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    nrst          = 1'b0;
    bus.req       = 4'b0000;
    bus.req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    bus.fifo_full = 1'b0;
    bus.rd_fire   = 1'b0;

    // All four requesting: pairs of grants in index order until the FIFO fills.
    do_reset("rst1", 4'b1111);
    cyc("t1c0", 4'b1111, 1'b0, 1'b0, 4'b0001, 0);
    cyc("t1c1", 4'b1111, 1'b0, 1'b0, 4'b0001, 1);
    cyc("t1c2", 4'b1111, 1'b0, 1'b0, 4'b0010, 2);
    cyc("t1c3", 4'b1111, 1'b0, 1'b0, 4'b0010, 3);
    cyc("t1c4", 4'b1111, 1'b0, 1'b0, 4'b0100, 4);
    cyc("t1c5", 4'b1111, 1'b0, 1'b0, 4'b0100, 5);
    cyc("t1c6", 4'b1111, 1'b0, 1'b0, 4'b1000, 6);
    cyc("t1f0", 4'b1111, 1'b1, 1'b0, 4'b0000, 7);
    cyc("t1f1", 4'b1111, 1'b1, 1'b0, 4'b0000, 7);
    chk("t1.own", 32'(owner), 32'd3);

    // Single contender: back-to-back bursts, then the pointer sits past it.
    do_reset("rst2", 4'b0100);
    cyc("t2c0", 4'b0100, 1'b0, 1'b0, 4'b0100, 0);
    cyc("t2c1", 4'b0100, 1'b0, 1'b0, 4'b0100, 1);
    cyc("t2c2", 4'b0100, 1'b0, 1'b0, 4'b0100, 2);
    cyc("t2c3", 4'b0100, 1'b0, 1'b0, 4'b0100, 3);
    cyc("t2c4", 4'b1111, 1'b0, 1'b0, 4'b1000, 4);
    cyc("t2c5", 4'b0000, 1'b0, 1'b0, 4'b0000, 5);
    chk("t2.own", 32'(owner), 32'd3);

    // Owner drops mid-burst: requester 3 is granted in the same cycle.
    do_reset("rst3", 4'b0000);
    cyc("t3c0", 4'b0010, 1'b0, 1'b0, 4'b0010, 0);
    cyc("t3c1", 4'b1000, 1'b0, 1'b0, 4'b1000, 1);
    cyc("t3c2", 4'b1000, 1'b0, 1'b0, 4'b1000, 2);
    cyc("t3c3", 4'b0000, 1'b0, 1'b0, 4'b0000, 3);
    chk("t3.own", 32'(owner), 32'd3);

    // Back-pressure inside a burst: owner 0 keeps exactly one more transfer.
    do_reset("rst4", 4'b0000);
    cyc("t4c0", 4'b0001, 1'b0, 1'b0, 4'b0001, 0);
    cyc("t4f0", 4'b0001, 1'b1, 1'b0, 4'b0000, 1);
    cyc("t4f1", 4'b0001, 1'b1, 1'b0, 4'b0000, 1);
    cyc("t4f2", 4'b0001, 1'b1, 1'b0, 4'b0000, 1);
    cyc("t4c1", 4'b0001, 1'b0, 1'b0, 4'b0001, 1);
    cyc("t4c2", 4'b0011, 1'b0, 1'b0, 4'b0010, 2);
    cyc("t4c3", 4'b0000, 1'b0, 1'b0, 4'b0000, 3);

    // Level accounting: simultaneous write+read, almost_full edges, saturation at 0.
    do_reset("rst5", 4'b0000);
    for (int n = 0; n < 5; n++) cyc("t5w", 4'b0001, 1'b0, 1'b0, 4'b0001, n);
    cyc("t5wr", 4'b0001, 1'b0, 1'b1, 4'b0001, 5);
    cyc("t5i0", 4'b0000, 1'b0, 1'b0, 4'b0000, 5);
    cyc("t5w6", 4'b0001, 1'b0, 1'b0, 4'b0001, 5);
    cyc("t5r",  4'b0000, 1'b0, 1'b1, 4'b0000, 6);
    cyc("t5i1", 4'b0000, 1'b0, 1'b0, 4'b0000, 5);
    do_reset("rst5b", 4'b0000);
    cyc("t5s0", 4'b0000, 1'b0, 1'b1, 4'b0000, 0);
    cyc("t5s1", 4'b0000, 1'b0, 1'b0, 4'b0000, 0);

    // Reset in the middle of owner 2's burst: priority restarts from index 0.
    do_reset("rst6", 4'b0000);
    cyc("t6c0", 4'b0100, 1'b0, 1'b0, 4'b0100, 0);
    @(negedge clk);
    bus.req = 4'b0110;
    #1;
    chk("t6.pre.gnt", 32'(bus.gnt), 32'b0100);
    nrst = 1'b0;
    #1;
    chk("t6.rst.gnt", 32'(bus.gnt), 32'd0);
    chk("t6.rst.we", 32'(bus.fifo_we), 32'd0);
    chk("t6.rst.lvl", 32'(level), 32'd0);
    chk("t6.rst.own", 32'(owner), 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    #1;
    chk("t6.rel.gnt", 32'(bus.gnt), 32'b0010);
    chk("t6.rel.din", 32'(bus.fifo_din), 32'hA1);
    cyc("t6c1", 4'b0110, 1'b0, 1'b0, 4'b0010, 1);
    cyc("t6c2", 4'b0000, 1'b0, 1'b0, 4'b0000, 2);
    chk("t6.own", 32'(owner), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter that shares one sync_fifo write port between NREQ producers.
- Grants at most one producer per cycle and enforces a per-owner burst limit.
- Drives the FIFO we/din pins and tracks FIFO occupancy for upstream flow control.
- Sits between the producer bank and the FIFO; the FIFO read side stays with the consumer.

Parameters:
- nreq, 4, number of requesters (2..8)
- dwith, 8, data width (matches the FIFO)
- dsize, 8, FIFO depth (matches the FIFO)
- max_burst, 2, maximum consecutive transfers granted to one owner (>=1)
- af_thresh, 6, level at or above which almost_full asserts

Ports:
- clk  in  1  clock, rising edge
- nrst  in  1  asynchronous active-low reset
- req  in  nreq  per-requester request; held with data until accepted
- req_data  in  nreq*dwith  packed data; requester i occupies bits [i*dwith +: dwith]
- gnt  out  nreq  one-hot accept; a transfer occurs when req[i] and gnt[i] are both high at a rising edge
- fifo_we  out  1  to FIFO we
- fifo_din  out  dwith  to FIFO din
- fifo_full  in  1  from FIFO d_full
- rd_fire  in  1  consumer read accepted (FIFO re and not d_empty)
- level  out  $clog2(dsize)+1  tracked FIFO occupancy
- almost_full  out  1  level >= af_thresh
- owner  out  $clog2(nreq)  current or last granted requester index (debug)

Behaviour:
- Reset (nrst low, asynchronous): state=IDLE, rr_ptr=0, owner=0, burst_cnt=0, level=0, almost_full=0. gnt=0 and fifo_we=0 while nrst is low, regardless of req.
- gnt is combinational from registered state plus the current req and fifo_full. There is zero-cycle accept latency: data reaches the FIFO on the same edge the grant is taken.
- fifo_we = |(gnt & req). fifo_din = req_data slice of the granted index, or 0 when there is no grant.
- fifo_full high: gnt=0 and fifo_we=0. State, owner, burst_cnt and rr_ptr all hold. A burst is not broken by back-pressure.
- Selection: the first set req bit scanning upward from rr_ptr, with wrap modulo nreq.
- State IDLE:
  - no req, or full: stay in IDLE.
  - otherwise grant the selected index k; owner<=k, burst_cnt<=1.
  - if max_burst==1: rr_ptr<=k+1 and stay in IDLE; else go to BURST.
- State BURST:
  - req[owner] high and not full: grant owner; burst_cnt++.
  - if burst_cnt reaches max_burst: rr_ptr<=owner+1 and go to IDLE.
  - req[owner] low: burst ends this cycle. rr_ptr<=owner+1, and selection from owner+1 proceeds in the same cycle (no bubble), following the IDLE rules.
- rr_ptr wraps from nreq-1 to 0.
- level counter:
  - +1 on fifo_we alone; -1 on rd_fire alone; unchanged when both fire in the same cycle.
  - Saturates at 0 and at dsize. Going past either limit is a bench error, not RTL behaviour.
- almost_full is registered and derived from the next level value, so it is coherent with level on the same cycle.
- The FIFO declares full at dsize-1 entries (one slot unused). Therefore level never exceeds dsize-1 in normal operation, and af_thresh must be <= dsize-1.
- Reset mid-burst: state is cleared immediately, and the burst owner loses priority after release.
- Data must be stable while req is high and unaccepted. gnt may toggle without a transfer if req is low.

Decomposition:
- Shared package fifo_arb_pkg holds the state enum (IDLE, BURST) and a localparam helper for the pointer width $clog2(nreq).
- One natural sub-module, rr_pick: a combinational rotating-priority encoder. Inputs req and start pointer; outputs valid and index.
- Counters, state register and muxing stay in fifo_wr_arbiter.

Test Plan:
- Reset, then req=4'b1111 held, rd_fire=0, max_burst=2 -> grants 0,0,1,1,2,2,3 on consecutive cycles; fifo_full after 7 writes; level=7; almost_full high from the 6th write.
- Only req[2] held, max_burst=2 -> grants 2,2,2,2 with no idle cycle; rr_ptr cycles correctly with a single contender.
- Owner 1 drops req after its first transfer while req[3] is high -> the same cycle grants 3; no bubble.
- fifo_full asserted during owner 0's burst (burst_cnt=1) for 3 cycles, then released -> gnt=0 for 3 cycles; owner 0 then gets exactly one more transfer.
- Simultaneous fifo_we and rd_fire at level=5 -> level stays 5; rd_fire alone at level=0 -> level stays 0 (saturation).
- nrst pulsed low mid-burst with req asserted -> gnt, fifo_we and level go to 0 asynchronously; after release, the first grant goes to the lowest set req index from 0.
